// File: rtl/zoom_pkg.sv
// -----------------------------------------------------------------------------
// zoom_pkg
// Shared definitions for the zoom scan controller: FSM state encoding,
// zoom mode encoding and default coordinate/address widths.
// -----------------------------------------------------------------------------
package zoom_pkg;

    localparam int DEF_COORD_W = 10;
    localparam int DEF_ADDR_W  = 17;   // 320x240 = 76800 pixels

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } zoom_state_t;

    typedef enum logic [1:0] {
        MODO_COPY  = 2'b00,
        MODO_ZIN2  = 2'b01,
        MODO_ZOUT2 = 2'b10,
        MODO_ZIN4  = 2'b11
    } zoom_modo_t;

endpackage

// File: rtl/zoom_axis_counter.sv
// -----------------------------------------------------------------------------
// zoom_axis_counter
// One raster axis counter: counts up on i_en, wraps to 0 after i_max,
// synchronous clear has priority. o_next exposes the value the register
// takes on the coming edge so the parent can register derived values
// (source address) in the same cycle as the coordinate itself.
//
// Ports
//   clock, reset_n  system clock / async active-low reset
//   i_clear         force count to 0 on next edge
//   i_en            advance count
//   i_max           last value before wrap
//   o_count         current count
//   o_next          count after the coming edge
//   o_at_max        o_count == i_max
// -----------------------------------------------------------------------------
module zoom_axis_counter #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         i_clear,
    input  logic         i_en,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_at_max
);

    logic [W-1:0] r_count;

    assign o_count  = r_count;
    assign o_at_max = (r_count == i_max);

    always_comb begin
        o_next = r_count;
        if (i_clear) begin
            o_next = '0;
        end else if (i_en) begin
            o_next = o_at_max ? '0 : r_count + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end

endmodule

// File: rtl/zoom_scan_controller.sv
// -----------------------------------------------------------------------------
// zoom_scan_controller
// Sequences one zoom operation: validates the latched configuration, then
// walks destination pixels in raster order (x fastest), presenting the
// nearest-neighbour source address and destination address for each pixel
// with a valid/ready handshake.
//
// Optional feature macro: ZOOM_FRAME_COUNT_EN adds a 16-bit frame_count
// output counting completed operations.
//
// Ports
//   clock, reset_n          system clock / async active-low reset
//   start                   begin operation (IDLE only)
//   config_mudou            synchronous abort, highest priority
//   modo                    00 copy, 01 x2, 10 /2, 11 x4
//   largura_src/altura_src  source frame dimensions
//   px_ready                datapath accepts current pixel
//   px_valid                dst_x/dst_y/src_addr/dst_addr valid
//   dst_x, dst_y            destination coordinate
//   src_addr, dst_addr      source / destination pixel address
//   busy                    high in CHECK and SCAN
//   done                    one-cycle pulse after last pixel
//   erro                    sticky invalid-configuration flag
//   frame_count             (ZOOM_FRAME_COUNT_EN) completed frames
//
// State | meaning
// IDLE  | waiting for start; configuration latched on accept
// CHECK | one cycle: derive destination size, flag bad configuration
// SCAN  | presenting pixels, advancing on px_valid && px_ready
// DONE  | one cycle: done pulse
// -----------------------------------------------------------------------------
module zoom_scan_controller
    import zoom_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               config_mudou,
    input  logic [1:0]         modo,
    input  logic [COORD_W-1:0] largura_src,
    input  logic [COORD_W-1:0] altura_src,
    input  logic               px_ready,
    output logic               px_valid,
    output logic [COORD_W-1:0] dst_x,
    output logic [COORD_W-1:0] dst_y,
    output logic [ADDR_W-1:0]  src_addr,
    output logic [ADDR_W-1:0]  dst_addr,
    output logic               busy,
    output logic               done,
    output logic               erro
`ifdef ZOOM_FRAME_COUNT_EN
   ,output logic [15:0]        frame_count
`endif
);

    zoom_state_t        r_state;
    zoom_state_t        w_state_next;
    zoom_modo_t         r_modo;
    logic [COORD_W-1:0] r_larg_src;
    logic [COORD_W-1:0] r_alt_src;
    logic [COORD_W-1:0] r_larg_dst;
    logic [COORD_W-1:0] r_alt_dst;
    logic               r_erro;
    logic [ADDR_W-1:0]  r_src_addr;
    logic [ADDR_W-1:0]  r_dst_addr;

    // Two extra bits so x2/x4 overflow of COORD_W is visible.
    logic [COORD_W+1:0] w_larg_ext;
    logic [COORD_W+1:0] w_alt_ext;
    logic               w_cfg_err;
    logic               w_accept;
    logic               w_transfer;
    logic               w_last;
    logic               w_cnt_clear;
    logic               w_x_at_max;
    logic               w_y_at_max;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic [COORD_W:0]   w_sx;
    logic [COORD_W:0]   w_sy;
    logic [ADDR_W-1:0]  w_src_next;

    function automatic logic [COORD_W+1:0] scale_dim(input zoom_modo_t m,
                                                    input logic [COORD_W-1:0] d);
        case (m)
            MODO_ZIN2:  scale_dim = {1'b0, d, 1'b0};
            MODO_ZIN4:  scale_dim = {d, 2'b00};
            MODO_ZOUT2: scale_dim = {3'b000, d[COORD_W-1:1]};
            default:    scale_dim = {2'b00, d};
        endcase
    endfunction

    function automatic logic [COORD_W:0] map_coord(input zoom_modo_t m,
                                                  input logic [COORD_W-1:0] c);
        case (m)
            MODO_ZIN2:  map_coord = {2'b00, c[COORD_W-1:1]};
            MODO_ZIN4:  map_coord = {3'b000, c[COORD_W-1:2]};
            MODO_ZOUT2: map_coord = {c, 1'b0};
            default:    map_coord = {1'b0, c};
        endcase
    endfunction

    assign w_larg_ext = scale_dim(r_modo, r_larg_src);
    assign w_alt_ext  = scale_dim(r_modo, r_alt_src);

    assign w_cfg_err = (r_larg_src == '0) || (r_alt_src == '0)
                    || (w_larg_ext == '0) || (w_alt_ext == '0)
                    || (|w_larg_ext[COORD_W+1:COORD_W])
                    || (|w_alt_ext[COORD_W+1:COORD_W]);

    assign w_accept    = (r_state == IDLE) && start && !config_mudou;
    assign w_transfer  = (r_state == SCAN) && px_ready;
    assign w_last      = w_transfer && w_x_at_max && w_y_at_max;
    assign w_cnt_clear = config_mudou || (r_state != SCAN);

    zoom_axis_counter #(.W(COORD_W)) u_cnt_x (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_cnt_clear),
        .i_en     (w_transfer),
        .i_max    (r_larg_dst - COORD_W'(1)),
        .o_count  (dst_x),
        .o_next   (w_x_next),
        .o_at_max (w_x_at_max)
    );

    zoom_axis_counter #(.W(COORD_W)) u_cnt_y (
        .clock    (clock),
        .reset_n  (reset_n),
        .i_clear  (w_cnt_clear),
        .i_en     (w_transfer && w_x_at_max),
        .i_max    (r_alt_dst - COORD_W'(1)),
        .o_count  (dst_y),
        .o_next   (w_y_next),
        .o_at_max (w_y_at_max)
    );

    // Source address is computed from the counters' next values and
    // registered alongside them, keeping src_addr coherent with dst_x/dst_y.
    // Multiplying in ADDR_W bits gives the same result as truncating the
    // full product.
    assign w_sx       = map_coord(r_modo, w_x_next);
    assign w_sy       = map_coord(r_modo, w_y_next);
    assign w_src_next = ADDR_W'(w_sy) * ADDR_W'(r_larg_src) + ADDR_W'(w_sx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        px_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                busy = 1'b1;
                if (config_mudou || w_cfg_err) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = SCAN;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                px_valid = 1'b1;
                if (config_mudou) begin
                    w_state_next = IDLE;
                end else if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_modo     <= MODO_COPY;
            r_larg_src <= '0;
            r_alt_src  <= '0;
            r_larg_dst <= '0;
            r_alt_dst  <= '0;
            r_erro     <= 1'b0;
            r_src_addr <= '0;
            r_dst_addr <= '0;
        end else begin
            if (w_accept) begin
                r_modo     <= zoom_modo_t'(modo);
                r_larg_src <= largura_src;
                r_alt_src  <= altura_src;
                r_erro     <= 1'b0;
            end
            if (r_state == CHECK) begin
                r_larg_dst <= w_larg_ext[COORD_W-1:0];
                r_alt_dst  <= w_alt_ext[COORD_W-1:0];
                if (!config_mudou && w_cfg_err) begin
                    r_erro <= 1'b1;
                end
            end
            r_src_addr <= w_src_next;
            if (w_cnt_clear || w_last) begin
                r_dst_addr <= '0;
            end else if (w_transfer) begin
                r_dst_addr <= r_dst_addr + ADDR_W'(1);
            end
        end
    end

    assign erro     = r_erro;
    assign src_addr = r_src_addr;
    assign dst_addr = r_dst_addr;

`ifdef ZOOM_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_count <= '0;
        end else if (r_state == DONE) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_zoom_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_zoom_scan_controller
// Drives zoom operations (directed and random) and compares every presented
// pixel against a list generated from the zoom rules with plain loops.
// -----------------------------------------------------------------------------
module tb_zoom_scan_controller;

    localparam int CW = 10;
    localparam int AW = 17;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          config_mudou = 1'b0;
    logic [1:0]    modo = 2'b00;
    logic [CW-1:0] largura_src = '0;
    logic [CW-1:0] altura_src = '0;
    logic          px_ready = 1'b0;
    logic          px_valid;
    logic [CW-1:0] dst_x;
    logic [CW-1:0] dst_y;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          busy;
    logic          done;
    logic          erro;
`ifdef ZOOM_FRAME_COUNT_EN
    logic [15:0]   frame_count;
    int            exp_frames = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int x;
        int y;
        int src;
        int dst;
    } pix_t;

    pix_t exp_q[$];

    zoom_scan_controller dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .config_mudou (config_mudou),
        .modo         (modo),
        .largura_src  (largura_src),
        .altura_src   (altura_src),
        .px_ready     (px_ready),
        .px_valid     (px_valid),
        .dst_x        (dst_x),
        .dst_y        (dst_y),
        .src_addr     (src_addr),
        .dst_addr     (dst_addr),
        .busy         (busy),
        .done         (done),
        .erro         (erro)
`ifdef ZOOM_FRAME_COUNT_EN
       ,.frame_count  (frame_count)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected pixel sequence from the zoom rules.
    task automatic build_model(input int m, input int w, input int h, output int err);
        int dw, dh, sx, sy;
        pix_t p;
        case (m)
            0:       begin dw = w;     dh = h;     end
            1:       begin dw = 2 * w; dh = 2 * h; end
            2:       begin dw = w / 2; dh = h / 2; end
            default: begin dw = 4 * w; dh = 4 * h; end
        endcase
        err = (w == 0 || h == 0 || dw == 0 || dh == 0 || dw >= (1 << CW) || dh >= (1 << CW)) ? 1 : 0;
        exp_q.delete();
        if (err == 0) begin
            for (int y = 0; y < dh; y++) begin
                for (int x = 0; x < dw; x++) begin
                    case (m)
                        1:       begin sx = x / 2; sy = y / 2; end
                        2:       begin sx = x * 2; sy = y * 2; end
                        3:       begin sx = x / 4; sy = y / 4; end
                        default: begin sx = x;     sy = y;     end
                    endcase
                    p.x   = x;
                    p.y   = y;
                    p.src = (sy * w + sx) % (1 << AW);
                    p.dst = (y * dw + x) % (1 << AW);
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    // rmode: 0 always ready, 1 random ready, 2 three-cycle stall at pixel 5.
    // abort_at: pixel index at which config_mudou fires (-1 = never).
    task automatic run_op(input int m, input int w, input int h, input int rmode, input int abort_at);
        int  err;
        int  n;
        int  cyc;
        int  stall_left;
        int  budget;
        bit  stop;
        logic rdy;
        build_model(m, w, h, err);
        start       = 1'b1;
        modo        = 2'(m);
        largura_src = CW'(w);
        altura_src  = CW'(h);
        px_ready    = 1'b0;
        @(negedge clock);
        check("check_busy", 32'(busy), 1);
        check("check_valid", 32'(px_valid), 0);
        check("erro_cleared", 32'(erro), 0);
        start       = 1'b0;
        modo        = 2'($urandom);
        largura_src = CW'($urandom);
        altura_src  = CW'($urandom);
        @(negedge clock);
        if (err != 0) begin
            check("err_flag", 32'(erro), 1);
            check("err_valid", 32'(px_valid), 0);
            check("err_busy", 32'(busy), 0);
            check("err_done", 32'(done), 0);
            return;
        end
        n          = 0;
        cyc        = 0;
        stall_left = 3;
        stop       = 1'b0;
        budget     = exp_q.size() * 8 + 50;
        while (n < exp_q.size()) begin
            check("scan_valid", 32'(px_valid), 1);
            check("scan_busy", 32'(busy), 1);
            check("dst_x", 32'(dst_x), exp_q[n].x);
            check("dst_y", 32'(dst_y), exp_q[n].y);
            check("src_addr", 32'(src_addr), exp_q[n].src);
            check("dst_addr", 32'(dst_addr), exp_q[n].dst);
            if (n == abort_at) begin
                config_mudou = 1'b1;
                px_ready     = 1'b1;
                start        = 1'b1;
                @(negedge clock);
                check("abort_valid", 32'(px_valid), 0);
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                check("abort_x", 32'(dst_x), 0);
                check("abort_y", 32'(dst_y), 0);
                check("abort_dst_addr", 32'(dst_addr), 0);
                check("abort_erro", 32'(erro), 0);
                config_mudou = 1'b0;
                start        = 1'b0;
                px_ready     = 1'b0;
                @(negedge clock);
                check("abort_no_done", 32'(done), 0);
                check("abort_idle", 32'(busy), 0);
                stop = 1'b1;
                break;
            end
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (n == 5 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                    end else begin
                        rdy = 1'b1;
                    end
                end
            endcase
            px_ready    = rdy;
            start       = 1'($urandom_range(0, 1));
            largura_src = CW'($urandom);
            if (rdy) n++;
            @(negedge clock);
            cyc++;
            if (cyc > budget) begin
                check("scan_timeout", 1, 0);
                stop = 1'b1;
                break;
            end
        end
        start    = 1'b0;
        px_ready = 1'b0;
        if (!stop) begin
            check("done_pulse", 32'(done), 1);
            check("done_valid", 32'(px_valid), 0);
            check("done_busy", 32'(busy), 0);
            @(negedge clock);
            check("done_width", 32'(done), 0);
            check("done_idle", 32'(busy), 0);
            check("done_erro", 32'(erro), 0);
`ifdef ZOOM_FRAME_COUNT_EN
            exp_frames = (exp_frames + 1) % 65536;
            check("frame_count", 32'(frame_count), exp_frames);
`endif
        end
    endtask

    initial begin
        int m, w, h, ab;

        repeat (3) @(negedge clock);
        check("rst_valid", 32'(px_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_erro", 32'(erro), 0);
        check("rst_x", 32'(dst_x), 0);
        check("rst_src", 32'(src_addr), 0);
        check("rst_dst", 32'(dst_addr), 0);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(0, 4, 3, 0, -1);       // copy 4x3
        run_op(1, 2, 2, 0, -1);       // x2 -> 4x4
        run_op(2, 5, 4, 0, -1);       // /2 -> 2x2, src 0,2,10,12
        run_op(0, 4, 3, 2, -1);       // backpressure at pixel 5

        run_op(3, 300, 4, 0, -1);     // x4 width overflow
        @(negedge clock);
        check("err_sticky", 32'(erro), 1);
        run_op(0, 0, 3, 0, -1);       // zero width
        run_op(2, 1, 4, 0, -1);       // /2 of width 1 gives zero
        run_op(0, 3, 2, 1, -1);       // valid start clears erro

        run_op(0, 4, 3, 0, 7);        // abort at pixel 7
        run_op(0, 4, 3, 0, 11);       // abort on last-pixel transfer

        start        = 1'b1;
        config_mudou = 1'b1;
        @(negedge clock);
        check("start_abort_idle", 32'(busy), 0);
        start        = 1'b0;
        config_mudou = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 25; i++) begin
            m  = $urandom_range(0, 3);
            w  = $urandom_range(0, 8);
            h  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
            run_op(m, w, h, $urandom_range(0, 1), ab);
        end

        // asynchronous reset in the middle of a scan
        start       = 1'b1;
        modo        = 2'b00;
        largura_src = CW'(8);
        altura_src  = CW'(8);
        px_ready    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        check("pre_reset_valid", 32'(px_valid), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_valid", 32'(px_valid), 0);
        check("areset_busy", 32'(busy), 0);
        check("areset_done", 32'(done), 0);
        check("areset_x", 32'(dst_x), 0);
        check("areset_y", 32'(dst_y), 0);
        check("areset_src", 32'(src_addr), 0);
        check("areset_dst", 32'(dst_addr), 0);
        check("areset_erro", 32'(erro), 0);
`ifdef ZOOM_FRAME_COUNT_EN
        check("areset_frames", 32'(frame_count), 0);
        exp_frames = 0;
`endif
        px_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run_op(0, 2, 2, 0, -1);
        run_op(0, 3, 1, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
